// File: rtl/lab6_g41_pattern_gen.sv
// rtl/lab6_g41_pattern_gen.sv - serial MSB-first pattern generator with repeat count and inter-repetition gap
module lab6_g41_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        pattern,
    input  logic [$clog2(WIDTH):0]  len,
    input  logic [3:0]              reps,
    output logic                    a,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    localparam int LW = $clog2(WIDTH) + 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       rep_q, rep_d;
    logic [3:0]       gap_q, gap_d;
    logic [LW-1:0]    len_clamp;
    logic [IW-1:0]    idx_reload;
    logic             a_d, valid_d, busy_d, done_d;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        idx_d      = idx_q;
        rep_d      = rep_q;
        gap_d      = gap_q;
        len_clamp  = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
        idx_reload = IW'(len_q - 1'b1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d = pattern;
                    len_d = len_clamp;
                    rep_d = reps;
                    gap_d = 4'd0;
                    if (len_clamp == '0 || reps == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEND;
                        idx_d   = IW'(len_clamp - 1'b1);
                    end
                end
            end
            S_SEND: begin
                if (idx_q == '0) begin
                    rep_d = rep_q - 4'd1;
                    // rep_q counts the repetition now finishing, so 1 means it was the last
                    if (rep_q == 4'd1) begin
                        state_d = S_DONE;
                    end else if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_M1;
                    end else begin
                        idx_d = idx_reload;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_SEND;
                    idx_d   = idx_reload;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the state being entered so they can be registered alongside it
        valid_d = (state_d == S_SEND);
        a_d     = valid_d & pat_d[idx_d];
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            a       <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            a       <= a_d;
            valid   <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
